// File: rtl/pcs_pkg.sv
// pcs_pkg: shared state type and 8b/10b symbol constants for the PCS TX scheduler
package pcs_pkg;
    typedef enum logic [1:0] {ELEC_IDLE, IDLE, DATA, SKP} pcs_tx_sched_state_t;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] D0_0 = 8'h00;
    localparam logic [31:0] SKP_OS_WORD = {K28_0, K28_0, K28_0, K28_5};
    localparam logic [3:0] SKP_OS_K = 4'hF;
endpackage

// File: rtl/pcs_tx_scheduler_if.sv
// pcs_tx_scheduler_if: MAC-side handshake and scheduled-word bus of the TX scheduler
interface pcs_tx_scheduler_if;
    logic [31:0] MAC_TX_Data;
    logic [3:0] MAC_TX_Datak;
    logic MAC_Data_En;
    logic TxElecIdle;
    logic MAC_TX_Ready;
    logic [31:0] Sched_Data;
    logic [3:0] Sched_Datak;
    logic Sched_Valid;
    logic Sched_ElecIdle;
    logic SKP_Inserted;
    modport master (
        output MAC_TX_Data, MAC_TX_Datak, MAC_Data_En, TxElecIdle,
        input MAC_TX_Ready, Sched_Data, Sched_Datak, Sched_Valid, Sched_ElecIdle, SKP_Inserted
    );
    modport slave (
        input MAC_TX_Data, MAC_TX_Datak, MAC_Data_En, TxElecIdle,
        output MAC_TX_Ready, Sched_Data, Sched_Datak, Sched_Valid, Sched_ElecIdle, SKP_Inserted
    );
endinterface

// File: rtl/pcs_skp_timer.sv
// pcs_skp_timer: SKP interval counter raising a pending flag once per interval
module pcs_skp_timer #(
    parameter int unsigned SKP_INTERVAL = 295,
    parameter int unsigned CNT_W = 16
) (
    input logic clk,
    input logic rst,
    input logic clr,
    input logic consume,
    output logic pending
);
    logic [CNT_W-1:0] cnt;
    logic wrap;
    assign wrap = cnt == CNT_W'(SKP_INTERVAL - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            pending <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            pending <= wrap | (pending & ~consume);
        end
    end
endmodule

// File: rtl/pcs_tx_scheduler.sv
// pcs_tx_scheduler: picks MAC data, SKP ordered set, logical idle or electrical idle each PCLK
module pcs_tx_scheduler
    import pcs_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 295,
    parameter int unsigned CNT_W = 16
) (
    input logic PCLK,
    input logic RST,
    pcs_tx_scheduler_if.slave bus
);
    pcs_tx_sched_state_t state, nxt;
    logic pending;
    assign bus.MAC_TX_Ready = (state != ELEC_IDLE) && !pending;
    // pending is always clear in ELEC_IDLE, so one priority chain covers every state
    always_comb begin
        nxt = bus.TxElecIdle ? ELEC_IDLE :
              pending ? SKP :
              (bus.MAC_Data_En && bus.MAC_TX_Ready) ? DATA : IDLE;
    end
    pcs_skp_timer #(.SKP_INTERVAL(SKP_INTERVAL), .CNT_W(CNT_W)) u_timer (
        .clk(PCLK),
        .rst(RST),
        .clr(nxt == ELEC_IDLE),
        .consume(nxt == SKP),
        .pending(pending)
    );
    always_ff @(posedge PCLK) begin
        if (RST) begin
            state <= ELEC_IDLE;
            bus.Sched_Data <= '0;
            bus.Sched_Datak <= '0;
            bus.Sched_Valid <= 1'b0;
            bus.Sched_ElecIdle <= 1'b1;
            bus.SKP_Inserted <= 1'b0;
        end else begin
            state <= nxt;
            bus.Sched_Data <= nxt == SKP ? SKP_OS_WORD : nxt == DATA ? bus.MAC_TX_Data : {4{D0_0}};
            bus.Sched_Datak <= nxt == SKP ? SKP_OS_K : nxt == DATA ? bus.MAC_TX_Datak : 4'h0;
            bus.Sched_Valid <= nxt != ELEC_IDLE;
            bus.Sched_ElecIdle <= nxt == ELEC_IDLE;
            bus.SKP_Inserted <= nxt == SKP;
        end
    end
endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// tb_pcs_tx_scheduler: directed checks of the TX scheduler with an 8-cycle SKP interval
module tb_pcs_tx_scheduler;
    logic pclk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    pcs_tx_scheduler_if bus();
    pcs_tx_scheduler #(.SKP_INTERVAL(8), .CNT_W(4)) dut (.PCLK(pclk), .RST(rst), .bus(bus));
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.MAC_Data_En = 1'b0;
        bus.MAC_TX_Data = '0;
        bus.MAC_TX_Datak = '0;
        bus.TxElecIdle = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic skp;
        do_reset();
        checks++; if (bus.Sched_Data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 00000000", bus.Sched_Data); end
        checks++; if (bus.Sched_Datak !== 4'h0) begin fails++; $display("FAIL reset_datak: got %h expected 0", bus.Sched_Datak); end
        checks++; if (bus.Sched_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.Sched_Valid); end
        checks++; if (bus.Sched_ElecIdle !== 1'b1) begin fails++; $display("FAIL reset_elecidle: got %b expected 1", bus.Sched_ElecIdle); end
        checks++; if (bus.SKP_Inserted !== 1'b0) begin fails++; $display("FAIL reset_skp: got %b expected 0", bus.SKP_Inserted); end
        checks++; if (bus.MAC_TX_Ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.MAC_TX_Ready); end
        for (int i = 1; i <= 25; i++) begin
            tick();
            skp = (i > 1) && (i % 8 == 1);
            checks++; if (bus.SKP_Inserted !== skp) begin fails++; $display("FAIL idle_skp c%0d: got %b expected %b", i, bus.SKP_Inserted, skp); end
            checks++; if (bus.Sched_Data !== (skp ? 32'h1C1C1CBC : 32'h0)) begin fails++; $display("FAIL idle_data c%0d: got %h expected %h", i, bus.Sched_Data, skp ? 32'h1C1C1CBC : 32'h0); end
            checks++; if (bus.Sched_Datak !== (skp ? 4'hF : 4'h0)) begin fails++; $display("FAIL idle_datak c%0d: got %h", i, bus.Sched_Datak); end
            checks++; if (bus.Sched_Valid !== 1'b1 || bus.Sched_ElecIdle !== 1'b0) begin fails++; $display("FAIL idle_valid c%0d: got valid %b elecidle %b expected 1 0", i, bus.Sched_Valid, bus.Sched_ElecIdle); end
            checks++; if (bus.MAC_TX_Ready !== (i % 8 != 0)) begin fails++; $display("FAIL idle_ready c%0d: got %b expected %b", i, bus.MAC_TX_Ready, i % 8 != 0); end
        end
    endtask

    task automatic test_stream();
        logic [31:0] word = 32'd1;
        logic [31:0] exp_word = 32'd1;
        logic [31:0] exp;
        logic rdy;
        do_reset();
        bus.MAC_Data_En = 1'b1;
        bus.MAC_TX_Data = word;
        for (int i = 1; i <= 26; i++) begin
            rdy = bus.MAC_TX_Ready;
            tick();
            if (rdy) begin word++; bus.MAC_TX_Data = word; end
            if (i == 1) exp = 32'h0;
            else if (i % 8 == 1) exp = 32'h1C1C1CBC;
            else begin exp = exp_word; exp_word++; end
            checks++; if (bus.Sched_Data !== exp) begin fails++; $display("FAIL stream_data c%0d: got %h expected %h", i, bus.Sched_Data, exp); end
            checks++; if (bus.SKP_Inserted !== (i > 1 && i % 8 == 1)) begin fails++; $display("FAIL stream_skp c%0d: got %b", i, bus.SKP_Inserted); end
            checks++; if (bus.MAC_TX_Ready !== (i % 8 != 0)) begin fails++; $display("FAIL stream_ready c%0d: got %b expected %b", i, bus.MAC_TX_Ready, i % 8 != 0); end
        end
        bus.MAC_Data_En = 1'b0;
    endtask

    task automatic test_k_word();
        do_reset();
        bus.MAC_Data_En = 1'b1;
        bus.MAC_TX_Data = 32'h000000BC;
        bus.MAC_TX_Datak = 4'b0001;
        tick();
        tick();
        bus.MAC_Data_En = 1'b0;
        checks++; if (bus.Sched_Data !== 32'h000000BC) begin fails++; $display("FAIL kword_data: got %h expected 000000bc", bus.Sched_Data); end
        checks++; if (bus.Sched_Datak !== 4'b0001) begin fails++; $display("FAIL kword_datak: got %b expected 0001", bus.Sched_Datak); end
        checks++; if (bus.SKP_Inserted !== 1'b0) begin fails++; $display("FAIL kword_skp: got %b expected 0", bus.SKP_Inserted); end
        bus.MAC_TX_Datak = 4'b0000;
    endtask

    task automatic test_elec_idle();
        do_reset();
        for (int i = 1; i <= 8; i++) tick();
        checks++; if (bus.MAC_TX_Ready !== 1'b0) begin fails++; $display("FAIL ei_pending: got ready %b expected 0", bus.MAC_TX_Ready); end
        bus.TxElecIdle = 1'b1;
        bus.MAC_Data_En = 1'b1;
        bus.MAC_TX_Data = 32'hDEADBEEF;
        for (int i = 9; i <= 11; i++) begin
            tick();
            checks++; if (bus.Sched_Valid !== 1'b0 || bus.Sched_ElecIdle !== 1'b1) begin fails++; $display("FAIL ei_state c%0d: got valid %b elecidle %b expected 0 1", i, bus.Sched_Valid, bus.Sched_ElecIdle); end
            checks++; if (bus.SKP_Inserted !== 1'b0 || bus.Sched_Data !== 32'h0) begin fails++; $display("FAIL ei_out c%0d: got skp %b data %h expected 0 00000000", i, bus.SKP_Inserted, bus.Sched_Data); end
            checks++; if (bus.MAC_TX_Ready !== 1'b0) begin fails++; $display("FAIL ei_ready c%0d: got %b expected 0", i, bus.MAC_TX_Ready); end
        end
        bus.TxElecIdle = 1'b0;
        bus.MAC_Data_En = 1'b0;
        for (int i = 12; i <= 20; i++) begin
            tick();
            checks++; if (bus.SKP_Inserted !== (i == 20)) begin fails++; $display("FAIL ei_resume_skp c%0d: got %b expected %b", i, bus.SKP_Inserted, i == 20); end
            checks++; if (bus.Sched_Valid !== 1'b1) begin fails++; $display("FAIL ei_resume_valid c%0d: got %b expected 1", i, bus.Sched_Valid); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 1; i <= 8; i++) tick();
        bus.MAC_Data_En = 1'b1;
        bus.MAC_TX_Data = 32'hA5A50001;
        tick();
        checks++; if (bus.Sched_Data !== 32'h1C1C1CBC) begin fails++; $display("FAIL hold_skp: got %h expected 1c1c1cbc", bus.Sched_Data); end
        checks++; if (bus.MAC_TX_Ready !== 1'b1) begin fails++; $display("FAIL hold_ready: got %b expected 1", bus.MAC_TX_Ready); end
        tick();
        bus.MAC_Data_En = 1'b0;
        checks++; if (bus.Sched_Data !== 32'hA5A50001) begin fails++; $display("FAIL hold_word: got %h expected a5a50001", bus.Sched_Data); end
        tick();
        checks++; if (bus.Sched_Data !== 32'h0 || bus.Sched_Valid !== 1'b1) begin fails++; $display("FAIL hold_once: got data %h valid %b expected 00000000 1", bus.Sched_Data, bus.Sched_Valid); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        bus.MAC_Data_En = 1'b1;
        bus.MAC_TX_Data = 32'h00000055;
        tick();
        tick();
        checks++; if (bus.Sched_Data !== 32'h00000055) begin fails++; $display("FAIL rstmid_pre: got %h expected 00000055", bus.Sched_Data); end
        rst = 1'b1;
        tick();
        checks++; if (bus.Sched_Data !== 32'h0 || bus.Sched_Valid !== 1'b0) begin fails++; $display("FAIL rstmid_data: got data %h valid %b expected 00000000 0", bus.Sched_Data, bus.Sched_Valid); end
        checks++; if (bus.Sched_ElecIdle !== 1'b1 || bus.MAC_TX_Ready !== 1'b0 || bus.SKP_Inserted !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: got elecidle %b ready %b skp %b expected 1 0 0", bus.Sched_ElecIdle, bus.MAC_TX_Ready, bus.SKP_Inserted); end
        rst = 1'b0;
        bus.MAC_Data_En = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_k_word();
        test_elec_idle();
        test_hold();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
